// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared state encodings and sizes for the 8-way round-robin arbiter
package rr_arbiter8_pkg;
    localparam int N_REQ = 8;
    localparam int ID_W  = 3;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between requesters (master) and the arbiter (slave)
interface rr_arbiter8_if;
    import rr_arbiter8_pkg::*;
    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_valid;
    logic             idle;
    logic             timeout;
    modport master (output req, done, input grant, grant_id, grant_valid, idle, timeout);
    modport slave  (input req, done, output grant, grant_id, grant_valid, idle, timeout);
endinterface

// File: rtl/rr_arbiter8_prio_pick.sv
// rr_prio_pick: rotating priority pick, first set req bit scanning upward from ptr with wrap
module rr_prio_pick
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  win_id,
    output logic             any
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [ID_W-1:0]    off;
    // rotate right by ptr, encode the lowest set bit, then undo the rotation
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) off = ID_W'(i);
        win_id = off + ptr;
        any = |req;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with held grant and release turnaround; ARB_TIMEOUT_EN adds forced release
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter8_if.slave bus
);
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD must be in 2..255");
    end
    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  win_id;
    logic             any;
    logic             rel;
    logic             hold_exp;
    rr_prio_pick u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .win_id (win_id),
        .any    (any)
    );
    assign rel = bus.done | ~bus.req[id_q];
`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;
    assign hold_exp = (state_q == S_GRANT) && (cnt_q == 8'(MAX_HOLD - 1));
    // hold counter runs only while granted and restarts on each new grant
    always_comb begin
        cnt_d = (state_q == S_GRANT) ? cnt_q + 8'd1 : 8'd0;
        to_d  = hold_exp & ~rel;
    end
    // counter and timeout pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
    assign bus.timeout = to_q;
`else
    assign hold_exp    = 1'b0;
    assign bus.timeout = 1'b0;
`endif
    // next-state: pick in idle, hold until release, one turnaround cycle
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: if (any) begin
                state_d = S_GRANT;
                grant_d = N_REQ'(1) << win_id;
                id_d    = win_id;
            end
            S_GRANT: if (rel || hold_exp) begin
                state_d = S_RELEASE;
                grant_d = '0;
                ptr_d   = id_q + ID_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end
    // state, pointer and registered grant outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            id_q    <= id_d;
        end
    end
    assign bus.grant       = grant_q;
    assign bus.grant_id    = id_q;
    assign bus.grant_valid = |grant_q;
    assign bus.idle        = (state_q == S_IDLE);
endmodule
